ascon_seq: RTL and testbench
============================

Name: ascon_seq

Overview:
- Command-driven sequencer that runs one complete ASCON AEAD job on the existing ascon core plus FIFO wrapper.
- Fetches AD and PT 64-bit words from a single-port word memory and pushes them into the AD/PT FIFOs.
- Pulses start to the core, drains the CT FIFO back to memory and waits for the tag.
- Sits between the subsystem register/bus front-end (command source) and the wrapper; it is the only memory master for the job.

Parameters:
- DataAddrWidth, 7, width of ad_size_i/pt_size_i (64-bit word counts); must match the wrapper.
- MemAddrWidth, 8, word address width of the shared memory port.
- TimeoutWidth, 16, width of the no-progress watchdog counter (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  high only in IDLE; job accepted when cmd_valid_i && cmd_ready_o
- ad_base_i  in  MemAddrWidth  first AD word address
- pt_base_i  in  MemAddrWidth  first PT word address
- ct_base_i  in  MemAddrWidth  first CT word address
- ad_size_i  in  DataAddrWidth  AD word count
- pt_size_i  in  DataAddrWidth  PT word count (= CT word count)
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  MemAddrWidth  word address
- mem_wdata_o  out  64  write data
- mem_rdata_i  in  64  read data, valid exactly 1 cycle after a read request
- start_o  out  1  one-cycle start pulse to core
- ready_i  in  1  core ready
- tag_valid_i  in  1  core tag valid
- ad_push_o / ad_o  out  1 / 64  AD FIFO write
- ad_full_i  in  1  AD FIFO full
- pt_push_o / pt_o  out  1 / 64  PT FIFO write
- pt_full_i  in  1  PT FIFO full
- ct_pop_o  out  1  CT FIFO pop
- ct_i  in  64  CT FIFO head (fall-through)
- ct_empty_i  in  1  CT FIFO empty
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle timeout pulse (optional feature)

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0 except cmd_ready_o = 1. Asserting rst_n low mid-job aborts immediately. FIFO contents are the wrapper's concern.
- Accept: bases and sizes are latched on the cycle cmd_valid_i && cmd_ready_o. Input changes after acceptance have no effect.
- IDLE -> START on accept.
- START: hold until ready_i = 1, then assert start_o for exactly 1 cycle and go to RUN.
- RUN, one memory access per cycle, fixed priority:
  - (1) CT drain: if ct_empty_i = 0 and ct_cnt < pt_size, assert mem_req_o = 1, mem_we_o = 1, mem_addr_o = ct_base + ct_cnt, mem_wdata_o = ct_i and ct_pop_o = 1 in the same cycle; ct_cnt++.
  - (2) AD fetch: if ad_cnt < ad_size, no read outstanding and ad_full_i = 0, issue a read at ad_base + ad_cnt.
  - (3) PT fetch: only when ad_cnt = ad_size; same rules against pt_full_i, address pt_base + pt_cnt.
- Outstanding read: on the following cycle push mem_rdata_i with ad_push_o/ad_o (or pt_push_o/pt_o) and increment the matching counter. At most one read is in flight, so a FIFO never overflows; fetch throughput is 1 word per 2 cycles.
- Priority rationale: CT drain ranks first so the core never deadlocks on a full CT FIFO.
- Tag: tag_valid_i sets a sticky tag_seen flag at any time in RUN, including before the last CT word is written.
- RUN -> DONE when ad_cnt = ad_size, pt_cnt = pt_size, ct_cnt = pt_size, no read in flight and tag_seen = 1.
- DONE: done_o = 1 for 1 cycle, then IDLE; tag_seen is cleared.
- ad_size = 0 skips AD fetch. pt_size = 0 issues no PT reads and no CT writes; the job completes on tag_seen alone.
- Counter width is DataAddrWidth+1, so a full-range count does not wrap. Address sums wrap modulo 2^MemAddrWidth.
- cmd_valid_i while busy is ignored; the request is not queued.

Optional Feature:
- Macro ASCON_SEQ_TIMEOUT_EN.
- Enabled: a TimeoutWidth-bit counter clears on any push, pop, start_o or tag_valid_i and otherwise increments in START/RUN. When it reaches all-ones: err_o pulses 1 cycle, done_o is not asserted, state returns to IDLE and the counter clears.
- Disabled: the counter is absent and err_o is tied to 0.

Test Plan:
- ad_size = 2, pt_size = 3, bases 0x00/0x10/0x20, core model with FIFO depth 4 -> 2 AD pushes then 3 PT pushes, in order; 3 writes at 0x20..0x22 carrying the model's CT words; exactly 1 done_o pulse; cmd_ready_o returns to 1.
- ad_size = 0, pt_size = 0 -> no mem_req_o, one start_o; done_o 1 cycle after tag_valid_i.
- CT FIFO kept non-empty during AD fetch (pt_size = 4) -> CT write wins every contested cycle; no read is issued while a write is granted; final memory image is correct.
- ready_i held low 10 cycles after accept -> start_o fires on the first ready_i = 1 cycle only; cmd_valid_i pulses while busy are ignored.
- rst_n low mid-RUN (after 1 PT push) -> all outputs 0 and cmd_ready_o = 1 asynchronously; a new job then completes normally.
- ASCON_SEQ_TIMEOUT_EN defined, TimeoutWidth = 4, core never asserts tag_valid_i -> err_o pulses 15 idle cycles after the last activity; no done_o; return to IDLE.

Source files
------------

// File: rtl/ascon_seq.sv
// ASCON AEAD job sequencer: streams AD/PT words from memory into the core FIFOs and drains CT back.
// Define ASCON_SEQ_TIMEOUT_EN to add the no-progress watchdog on err_o; without it err_o is tied to 0.
module ascon_seq #(
  parameter int unsigned DataAddrWidth = 7,
  parameter int unsigned MemAddrWidth  = 8
`ifdef ASCON_SEQ_TIMEOUT_EN
  , parameter int unsigned TimeoutWidth = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [MemAddrWidth-1:0]  ad_base_i,
  input  logic [MemAddrWidth-1:0]  pt_base_i,
  input  logic [MemAddrWidth-1:0]  ct_base_i,
  input  logic [DataAddrWidth-1:0] ad_size_i,
  input  logic [DataAddrWidth-1:0] pt_size_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [MemAddrWidth-1:0]  mem_addr_o,
  output logic [63:0]              mem_wdata_o,
  input  logic [63:0]              mem_rdata_i,
  output logic                     start_o,
  input  logic                     ready_i,
  input  logic                     tag_valid_i,
  output logic                     ad_push_o,
  output logic [63:0]              ad_o,
  input  logic                     ad_full_i,
  output logic                     pt_push_o,
  output logic [63:0]              pt_o,
  input  logic                     pt_full_i,
  output logic                     ct_pop_o,
  input  logic [63:0]              ct_i,
  input  logic                     ct_empty_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // One extra bit so a full-range word count never wraps.
  localparam int unsigned CntW = DataAddrWidth + 1;

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [MemAddrWidth-1:0] adBase_q, adBase_d, ptBase_q, ptBase_d, ctBase_q, ctBase_d;
  logic [CntW-1:0]         adSize_q, adSize_d, ptSize_q, ptSize_d;
  logic [CntW-1:0]         adCnt_q, adCnt_d, ptCnt_q, ptCnt_d, ctCnt_q, ctCnt_d;
  logic                    rdPend_q, rdPend_d, rdPt_q, rdPt_d, tagSeen_q, tagSeen_d;

  logic ctWant, adWant, ptWant, jobDone;

  assign ctWant  = !ct_empty_i && (ctCnt_q < ptSize_q);
  assign adWant  = !rdPend_q && (adCnt_q < adSize_q) && !ad_full_i;
  assign ptWant  = !rdPend_q && (adCnt_q == adSize_q) && (ptCnt_q < ptSize_q) && !pt_full_i;
  // The tag may arrive on the very cycle everything else settles, so it counts immediately.
  assign jobDone = (adCnt_q == adSize_q) && (ptCnt_q == ptSize_q) && (ctCnt_q == ptSize_q)
                   && !rdPend_q && (tagSeen_q || tag_valid_i);

`ifdef ASCON_SEQ_TIMEOUT_EN
  logic [TimeoutWidth-1:0] toCnt_q, toCnt_d;
  logic                    activity;
`endif

  always_comb begin
    state_d     = state_q;
    adBase_d    = adBase_q;
    ptBase_d    = ptBase_q;
    ctBase_d    = ctBase_q;
    adSize_d    = adSize_q;
    ptSize_d    = ptSize_q;
    adCnt_d     = adCnt_q;
    ptCnt_d     = ptCnt_q;
    ctCnt_d     = ctCnt_q;
    rdPend_d    = rdPend_q;
    rdPt_d      = rdPt_q;
    tagSeen_d   = tagSeen_q;
    cmd_ready_o = 1'b0;
    busy_o      = (state_q != StIdle);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    start_o     = 1'b0;
    ad_push_o   = 1'b0;
    ad_o        = '0;
    pt_push_o   = 1'b0;
    pt_o        = '0;
    ct_pop_o    = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          adBase_d  = ad_base_i;
          ptBase_d  = pt_base_i;
          ctBase_d  = ct_base_i;
          adSize_d  = CntW'(ad_size_i);
          ptSize_d  = CntW'(pt_size_i);
          adCnt_d   = '0;
          ptCnt_d   = '0;
          ctCnt_d   = '0;
          rdPend_d  = 1'b0;
          tagSeen_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (ready_i) begin
          start_o = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (tag_valid_i) tagSeen_d = 1'b1;
        if (rdPend_q) begin
          rdPend_d = 1'b0;
          if (rdPt_q) begin
            pt_push_o = 1'b1;
            pt_o      = mem_rdata_i;
            ptCnt_d   = ptCnt_q + CntW'(1);
          end else begin
            ad_push_o = 1'b1;
            ad_o      = mem_rdata_i;
            adCnt_d   = adCnt_q + CntW'(1);
          end
        end
        // CT drain outranks fetches so a full CT FIFO can never stall the core.
        if (ctWant) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = ctBase_q + MemAddrWidth'(ctCnt_q);
          mem_wdata_o = ct_i;
          ct_pop_o    = 1'b1;
          ctCnt_d     = ctCnt_q + CntW'(1);
        end else if (adWant) begin
          mem_req_o  = 1'b1;
          mem_addr_o = adBase_q + MemAddrWidth'(adCnt_q);
          rdPend_d   = 1'b1;
          rdPt_d     = 1'b0;
        end else if (ptWant) begin
          mem_req_o  = 1'b1;
          mem_addr_o = ptBase_q + MemAddrWidth'(ptCnt_q);
          rdPend_d   = 1'b1;
          rdPt_d     = 1'b1;
        end
        if (jobDone) state_d = StDone;
      end
      StDone: begin
        done_o    = 1'b1;
        tagSeen_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ASCON_SEQ_TIMEOUT_EN
    err_o    = 1'b0;
    toCnt_d  = '0;
    activity = ad_push_o || pt_push_o || ct_pop_o || start_o || tag_valid_i;
    if ((state_q == StStart) || (state_q == StRun)) begin
      if (activity) begin
        toCnt_d = '0;
      end else if (&toCnt_q) begin
        err_o     = 1'b1;
        rdPend_d  = 1'b0;
        tagSeen_d = 1'b0;
        state_d   = StIdle;
      end else begin
        toCnt_d = toCnt_q + TimeoutWidth'(1);
      end
    end
`endif
  end

`ifndef ASCON_SEQ_TIMEOUT_EN
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      adBase_q  <= '0;
      ptBase_q  <= '0;
      ctBase_q  <= '0;
      adSize_q  <= '0;
      ptSize_q  <= '0;
      adCnt_q   <= '0;
      ptCnt_q   <= '0;
      ctCnt_q   <= '0;
      rdPend_q  <= 1'b0;
      rdPt_q    <= 1'b0;
      tagSeen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adBase_q  <= adBase_d;
      ptBase_q  <= ptBase_d;
      ctBase_q  <= ctBase_d;
      adSize_q  <= adSize_d;
      ptSize_q  <= ptSize_d;
      adCnt_q   <= adCnt_d;
      ptCnt_q   <= ptCnt_d;
      ctCnt_q   <= ctCnt_d;
      rdPend_q  <= rdPend_d;
      rdPt_q    <= rdPt_d;
      tagSeen_q <= tagSeen_d;
    end
  end

`ifdef ASCON_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toCnt_q <= '0;
    else        toCnt_q <= toCnt_d;
  end
`endif

endmodule

// File: tb/tb_ascon_seq.sv
// Self-checking bench for ascon_seq: memory, FIFO and core behaviour modelled at job level.
module tb_ascon_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o;
  logic [7:0]  ad_base_i, pt_base_i, ct_base_i;
  logic [6:0]  ad_size_i, pt_size_i;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [63:0] mem_wdata_o, mem_rdata_i;
  logic        start_o, ready_i, tag_valid_i;
  logic        ad_push_o, ad_full_i, pt_push_o, pt_full_i, ct_pop_o, ct_empty_i;
  logic [63:0] ad_o, pt_o, ct_i;
  logic        busy_o, done_o, err_o;

  always #5 clk = ~clk;

  ascon_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .ad_base_i(ad_base_i), .pt_base_i(pt_base_i), .ct_base_i(ct_base_i),
    .ad_size_i(ad_size_i), .pt_size_i(pt_size_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .start_o(start_o), .ready_i(ready_i), .tag_valid_i(tag_valid_i),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  logic [63:0] mem [256];
  logic [63:0] memInit [256];
  logic [63:0] adQ[$], ptQ[$], ctQ[$];
  logic [63:0] acc, tmpWord;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  int jAdBase, jPtBase, jCtBase, jAdSize, jPtSize;
  bit eager;
  logic [31:0] jobSeed;

  int adPushes, ptPushes, ctWrites, starts, dones, accepts, memReqs, protoErr, contestErr;
  int startCycle, doneCycle, tagCycle, acceptCycle;
  int adConsumed, ptConsumed, ctProduced;
  bit started, tagSent, readPending, pulsesOn, lastBusy, lastDone;

  logic        sReq, sWe, sAdPush, sPtPush, sStart;
  logic [7:0]  sAddr;
  logic [63:0] sWdata, sAdO, sPtO;

  // Every comparison in the bench funnels through here.
  task checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] eagerWord(input int i);
    return {jobSeed, 32'(i)};
  endfunction

  // Reference CT: eager core emits a tagged counter, normal core XORs PT with all AD words and the index.
  function automatic logic [63:0] expCt(input int i);
    logic [63:0] x;
    if (eager) return eagerWord(i);
    x = '0;
    for (int k = 0; k < jAdSize; k++) x = x ^ memInit[(jAdBase + k) % 256];
    return memInit[(jPtBase + i) % 256] ^ x ^ 64'(i);
  endfunction

  // One clock: observe the DUT at the falling edge, then apply the environment's reaction after the rising edge.
  task stepCycle;
    @(negedge clk);
    cycleCnt++;
    sReq = mem_req_o; sWe = mem_we_o; sAddr = mem_addr_o; sWdata = mem_wdata_o;
    sAdPush = ad_push_o; sAdO = ad_o; sPtPush = pt_push_o; sPtO = pt_o; sStart = start_o;
    if (cmd_valid_i && cmd_ready_o) begin accepts++; acceptCycle = cycleCnt; end
    if (cmd_ready_o === busy_o) protoErr++;
    if (mem_req_o) memReqs++;
    if (ct_pop_o !== (mem_req_o && mem_we_o)) protoErr++;
    if (ct_pop_o && (mem_wdata_o !== ct_i)) protoErr++;
    if ((ad_push_o || pt_push_o) !== readPending) protoErr++;
    if (ad_push_o && pt_push_o) protoErr++;
    if (mem_req_o && !mem_we_o && readPending) protoErr++;
    if (err_o) protoErr++;
    if (started && !ct_empty_i && (ctWrites < jPtSize) && !(mem_req_o && mem_we_o)) contestErr++;
    if (start_o) begin starts++; startCycle = cycleCnt; if (!ready_i) protoErr++; end
    if (done_o) begin dones++; doneCycle = cycleCnt; end
    if (tag_valid_i) tagCycle = cycleCnt;
    lastBusy = busy_o;
    lastDone = done_o;

    @(posedge clk);
    #1;
    readPending = sReq && !sWe;
    if (sReq && sWe) begin
      mem[sAddr] = sWdata;
      ctWrites++;
      if (ctQ.size() > 0) tmpWord = ctQ.pop_front();
    end
    mem_rdata_i = (sReq && !sWe) ? mem[sAddr] : {$urandom, $urandom};
    if (sAdPush) begin
      checkOutput("adPushData", sAdO, memInit[(jAdBase + adPushes) % 256]);
      adQ.push_back(sAdO);
      adPushes++;
    end
    if (sPtPush) begin
      checkOutput("ptPushData", sPtO, memInit[(jPtBase + ptPushes) % 256]);
      ptQ.push_back(sPtO);
      ptPushes++;
    end
    if (sStart) started = 1'b1;
    if (started) begin
      if (eager) begin
        if (adQ.size() > 0) begin tmpWord = adQ.pop_front(); adConsumed++; end
        if (ptQ.size() > 0) begin tmpWord = ptQ.pop_front(); ptConsumed++; end
        if (ctProduced < jPtSize && ctQ.size() < 4) begin
          ctQ.push_back(eagerWord(ctProduced));
          ctProduced++;
        end
      end else begin
        if (adQ.size() > 0) begin
          acc = acc ^ adQ.pop_front();
          adConsumed++;
        end else if (adConsumed == jAdSize && ptQ.size() > 0 && ctQ.size() < 4) begin
          ctQ.push_back(ptQ.pop_front() ^ acc ^ 64'(ctProduced));
          ptConsumed++;
          ctProduced++;
        end
      end
      tag_valid_i = 1'b0;
      if (!tagSent && adConsumed == jAdSize && ptConsumed == jPtSize && ctProduced == jPtSize) begin
        tag_valid_i = 1'b1;
        tagSent = 1'b1;
      end
    end
    ad_full_i  = (adQ.size() >= 4);
    pt_full_i  = (ptQ.size() >= 4);
    ct_empty_i = (ctQ.size() == 0);
    ct_i       = ct_empty_i ? {$urandom, $urandom} : ctQ[0];
    if (pulsesOn) cmd_valid_i = lastBusy && !lastDone && ($urandom_range(0, 2) == 0);
  endtask

  // Loads a fresh memory image, resets the environment model and presents one accepted command.
  task applyStimulus(input int adBase, input int ptBase, input int ctBase,
                     input int adSize, input int ptSize, input bit eagerIn, input int readyDelay);
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom};
      memInit[i] = mem[i];
    end
    adQ.delete(); ptQ.delete(); ctQ.delete();
    jAdBase = adBase; jPtBase = ptBase; jCtBase = ctBase; jAdSize = adSize; jPtSize = ptSize;
    eager = eagerIn; jobSeed = $urandom; acc = '0;
    adPushes = 0; ptPushes = 0; ctWrites = 0; starts = 0; dones = 0; accepts = 0;
    memReqs = 0; protoErr = 0; contestErr = 0;
    startCycle = -1; doneCycle = -1; tagCycle = -1; acceptCycle = -1;
    adConsumed = 0; ptConsumed = 0; ctProduced = 0;
    started = 1'b0; tagSent = 1'b0; readPending = 1'b0; pulsesOn = 1'b0;
    ready_i = 1'b1; tag_valid_i = 1'b0;
    ad_full_i = 1'b0; pt_full_i = 1'b0; ct_empty_i = 1'b1;
    ad_base_i = 8'(adBase); pt_base_i = 8'(ptBase); ct_base_i = 8'(ctBase);
    ad_size_i = 7'(adSize); pt_size_i = 7'(ptSize);
    cmd_valid_i = 1'b1;
    stepCycle();
    cmd_valid_i = 1'b0;
    ad_base_i = 8'($urandom); pt_base_i = 8'($urandom); ct_base_i = 8'($urandom);
    ad_size_i = 7'($urandom); pt_size_i = 7'($urandom);
    if (readyDelay > 0) begin
      ready_i = 1'b0;
      for (int d = 0; d < readyDelay; d++) stepCycle();
      ready_i = 1'b1;
    end
  endtask

  task finishJob(input string name, input int readyDelay, input bit pulses);
    int bad;
    int rest;
    bit inCt;
    pulsesOn = pulses;
    for (int c = 0; c < 3000 && dones == 0; c++) stepCycle();
    pulsesOn = 1'b0;
    cmd_valid_i = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput({name, ".doneCount"}, 64'(dones), 64'd1);
    checkOutput({name, ".cmdReady"}, 64'(cmd_ready_o), 64'd1);
    checkOutput({name, ".accepts"}, 64'(accepts), 64'd1);
    checkOutput({name, ".starts"}, 64'(starts), 64'd1);
    checkOutput({name, ".startCycle"}, 64'(startCycle), 64'(acceptCycle + readyDelay + 1));
    checkOutput({name, ".adPushes"}, 64'(adPushes), 64'(jAdSize));
    checkOutput({name, ".ptPushes"}, 64'(ptPushes), 64'(jPtSize));
    checkOutput({name, ".ctWrites"}, 64'(ctWrites), 64'(jPtSize));
    checkOutput({name, ".protocol"}, 64'(protoErr), 64'd0);
    checkOutput({name, ".ctPriority"}, 64'(contestErr), 64'd0);
    bad = 0;
    for (int i = 0; i < jPtSize; i++)
      if (mem[(jCtBase + i) % 256] !== expCt(i)) bad++;
    checkOutput({name, ".ctImage"}, 64'(bad), 64'd0);
    rest = 0;
    for (int a = 0; a < 256; a++) begin
      inCt = ((a - jCtBase + 256) % 256) < jPtSize;
      if (!inCt && mem[a] !== memInit[a]) rest++;
    end
    checkOutput({name, ".untouched"}, 64'(rest), 64'd0);
  endtask

  initial begin
    int ab, pb, cb, as, ps;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; ready_i = 1'b1; tag_valid_i = 1'b0;
    ad_base_i = '0; pt_base_i = '0; ct_base_i = '0; ad_size_i = '0; pt_size_i = '0;
    mem_rdata_i = '0; ad_full_i = 1'b0; pt_full_i = 1'b0; ct_i = '0; ct_empty_i = 1'b1;
    jAdSize = 0; jPtSize = 0; started = 1'b0; readPending = 1'b0; pulsesOn = 1'b0;
    #1;
    checkOutput("reset.outputs",
                64'({cmd_ready_o, busy_o, mem_req_o, mem_we_o, start_o, done_o,
                     ad_push_o, pt_push_o, ct_pop_o, err_o}), 64'(10'b1000000000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(8'h00, 8'h10, 8'h20, 2, 3, 1'b0, 0);
    finishJob("basic", 0, 1'b0);

    applyStimulus(8'h40, 8'h50, 8'h60, 0, 0, 1'b0, 0);
    finishJob("empty", 0, 1'b0);
    checkOutput("empty.memReqs", 64'(memReqs), 64'd0);
    checkOutput("empty.doneAfterTag", 64'(doneCycle - tagCycle), 64'd1);

    applyStimulus(8'h80, 8'h90, 8'hA0, 3, 4, 1'b1, 0);
    finishJob("ctFirst", 0, 1'b0);

    applyStimulus(8'h05, 8'h30, 8'h70, 2, 2, 1'b0, 10);
    finishJob("readyLate", 10, 1'b1);

    applyStimulus(8'h10, 8'h20, 8'h30, 1, 4, 1'b0, 0);
    for (int c = 0; c < 500 && ptPushes < 1; c++) stepCycle();
    checkOutput("midReset.reachedPt", 64'(ptPushes >= 1), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.outputs",
                64'({cmd_ready_o, busy_o, mem_req_o, mem_we_o, start_o, done_o,
                     ad_push_o, pt_push_o, ct_pop_o, err_o}), 64'(10'b1000000000));
    checkOutput("midReset.addr", 64'(mem_addr_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(8'h10, 8'h20, 8'h30, 1, 4, 1'b0, 0);
    finishJob("afterReset", 0, 1'b0);

    applyStimulus(8'hF0, 8'h70, 8'h76, 127, 5, 1'b0, 0);
    finishJob("fullAd", 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      as = $urandom_range(0, 20);
      ps = $urandom_range(0, 20);
      ab = $urandom_range(0, 255);
      pb = (ab + as + $urandom_range(0, 5)) % 256;
      cb = (pb + ps + $urandom_range(0, 5)) % 256;
      applyStimulus(ab, pb, cb, as, ps, 1'($urandom_range(0, 1)), j % 3);
      finishJob($sformatf("rand%0d", j), j % 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
